// File: rtl/atari_bus_pkg.sv
// atari_bus_pkg
//   Shared definitions for the 6507 bus decoder / cartridge mapper:
//   address-region enum, decode bit positions, Superchip RAM window offsets,
//   the classic Atari hotspot layouts (F8/F6/F4) and a bank-width helper.
package atari_bus_pkg;

  typedef enum logic [2:0] {
    REG_TIA,
    REG_RIOT,
    REG_ROM,
    REG_SCRAM_RD,
    REG_SCRAM_WR
  } region_e;

  localparam int CART_A12_BIT = 12;
  localparam int RIOT_A7_BIT  = 7;

  // Superchip ports, as offsets inside the 4 KB cartridge window.
  localparam logic [11:0] SC_WR_BASE = 12'h000;
  localparam logic [11:0] SC_RD_BASE = 12'h080;
  localparam logic [11:0] SC_SIZE    = 12'h080;

  // Standard Atari bank-switching schemes.
  localparam logic [11:0] HOT_BASE_F8  = 12'hFF8;
  localparam int          NUM_BANKS_F8 = 2;
  localparam logic [11:0] HOT_BASE_F6  = 12'hFF6;
  localparam int          NUM_BANKS_F6 = 4;
  localparam logic [11:0] HOT_BASE_F4  = 12'hFF4;
  localparam int          NUM_BANKS_F4 = 8;

  // Width of the bank register; a single bank still gets one bit.
  function automatic int bank_width(input int num_banks);
    return (num_banks <= 2) ? 1 : $clog2(num_banks);
  endfunction

endpackage

// File: rtl/superchip_ram.sv
// superchip_ram
//   128 x 8 cartridge RAM with a synchronous write port and an asynchronous
//   read port.
//   clk   : bus clock
//   we    : write enable, sampled at the rising edge
//   waddr : write index, wdata : write data
//   raddr : read index,  rdata : read data (combinational)
module superchip_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [128];

  // NOTE: storage has no reset; clearing 128 entries would need a counter or
  // a huge reset fan-out, and the software never relies on power-up content.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/atari_cart_mapper.sv
// atari_cart_mapper
//   6507 bus decoder with hotspot bank switching and optional Superchip RAM.
//   CLOCKBUS   : bus clock, one CPU bus cycle per rising edge
//   RES        : synchronous active-high reset (bank register only)
//   BUS_VALID  : qualifies the cycle; low during RDY/WSYNC stalls
//   CPU_Addr, CPU_R_W_n, CPU_Dout : CPU bus (R_W_n = 1 means read)
//   CPU_Din    : read-data mux back to the CPU
//   TIA_Dout, RIOT_Dout, ROM_Dout : peripheral read data
//   TIA_SEL, RIOT_SEL, ROM_CS     : combinational region selects
//   ROM_Addr   : {bank, CPU_Addr[11:0]}
//   BANK       : current bank register
module atari_cart_mapper
  import atari_bus_pkg::*;
#(
  parameter int          NUM_BANKS  = NUM_BANKS_F4,
  parameter logic [11:0] HOT_BASE   = HOT_BASE_F4,
  parameter int          RESET_BANK = NUM_BANKS - 1,
  parameter int          SC_RAM     = 0,
  parameter int          BANK_W     = bank_width(NUM_BANKS)
) (
  input  logic                CLOCKBUS,
  input  logic                RES,
  input  logic                BUS_VALID,
  input  logic [12:0]         CPU_Addr,
  input  logic                CPU_R_W_n,
  input  logic [7:0]          CPU_Dout,
  output logic [7:0]          CPU_Din,
  input  logic [7:0]          TIA_Dout,
  input  logic [7:0]          RIOT_Dout,
  input  logic [7:0]          ROM_Dout,
  output logic                TIA_SEL,
  output logic                RIOT_SEL,
  output logic                ROM_CS,
  output logic [12+BANK_W-1:0] ROM_Addr,
  output logic [BANK_W-1:0]   BANK
);

  // Illegal parameter sets are rejected at elaboration.
  if (!(NUM_BANKS == 1 || NUM_BANKS == 2 || NUM_BANKS == 4 || NUM_BANKS == 8))
  begin : g_bad_num_banks
    $error("atari_cart_mapper: NUM_BANKS must be 1, 2, 4 or 8");
  end
  if (BANK_W != bank_width(NUM_BANKS)) begin : g_bad_bank_w
    $error("atari_cart_mapper: BANK_W must not be overridden");
  end
  if (RESET_BANK < 0 || RESET_BANK >= NUM_BANKS) begin : g_bad_reset_bank
    $error("atari_cart_mapper: RESET_BANK out of range");
  end
  if (int'(HOT_BASE) + NUM_BANKS > 4096) begin : g_bad_hot_wrap
    $error("atari_cart_mapper: hotspot range leaves the cartridge window");
  end
  if (SC_RAM != 0 && NUM_BANKS > 1 && int'(HOT_BASE) < int'(SC_RD_BASE + SC_SIZE))
  begin : g_bad_hot_overlap
    $error("atari_cart_mapper: hotspots overlap the Superchip RAM ports");
  end

  logic [11:0] cart_off;
  region_e     region;

  assign cart_off = CPU_Addr[11:0];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    region = REG_TIA;
    if (CPU_Addr[CART_A12_BIT]) begin
      if (SC_RAM != 0 && (cart_off - SC_WR_BASE) < SC_SIZE) begin
        region = REG_SCRAM_WR;
      end else if (SC_RAM != 0 && (cart_off - SC_RD_BASE) < SC_SIZE) begin
        region = REG_SCRAM_RD;
      end else begin
        region = REG_ROM;
      end
    end else if (CPU_Addr[RIOT_A7_BIT]) begin
      region = REG_RIOT;
    end
  end

  assign TIA_SEL  = (region == REG_TIA);
  assign RIOT_SEL = (region == REG_RIOT);
  assign ROM_CS   = (region == REG_ROM);

  // Hotspot: unsigned offset from HOT_BASE; anything below HOT_BASE wraps
  // to a large value and fails the range test.
  logic [11:0] hot_off;
  logic        hot_hit;

  assign hot_off = cart_off - HOT_BASE;
  assign hot_hit = (NUM_BANKS > 1) && BUS_VALID && CPU_Addr[CART_A12_BIT] &&
                   (hot_off < 12'(NUM_BANKS));

  logic [BANK_W-1:0] bank_d, bank_q;

  always_comb begin
    bank_d = bank_q;
    if (hot_hit) begin
      bank_d = hot_off[BANK_W-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLOCKBUS) begin
    if (RES) begin
      bank_q <= BANK_W'(RESET_BANK);
    end else begin
      bank_q <= bank_d;
    end
  end

  assign BANK     = bank_q;
  // The hotspot cycle is still served from the old bank.
  assign ROM_Addr = {bank_q, cart_off};

  logic       ram_we;
  logic [7:0] ram_rdata;

  assign ram_we = BUS_VALID && !CPU_R_W_n && (region == REG_SCRAM_WR);

  if (SC_RAM != 0) begin : g_sc
    superchip_ram u_ram (
      .clk   (CLOCKBUS),
      .we    (ram_we),
      .waddr (CPU_Addr[6:0]),
      .wdata (CPU_Dout),
      .raddr (CPU_Addr[6:0]),
      .rdata (ram_rdata)
    );
  end else begin : g_no_sc
    logic unused_sc;
    assign unused_sc = ^{ram_we, CPU_Dout};
    assign ram_rdata = 8'hFF;
  end

  always_comb begin
    CPU_Din = TIA_Dout;
    case (region)
      REG_SCRAM_RD: CPU_Din = ram_rdata;
      // Reading the write port returns open-bus high and must not write.
      REG_SCRAM_WR: CPU_Din = 8'hFF;
      REG_ROM:      CPU_Din = ROM_Dout;
      REG_RIOT:     CPU_Din = RIOT_Dout;
      default:      CPU_Din = TIA_Dout;
    endcase
  end

endmodule

// File: doc/atari_cart_mapper.md
# atari_cart_mapper

Parametrised bus decoder and cartridge bank-switching mapper between the 6507 bus and the TIA, RIOT and cartridge ROM. It generalises the fixed 4 KB decode to 1..8 banks of 4 KB, selected by Atari-style hotspot accesses. It optionally adds 128 bytes of Superchip cartridge RAM. It owns the CPU read-data mux and drives the widened ROM address.

## Interface
- NUM_BANKS, 8, number of 4 KB banks; legal values are 1, 2, 4, 8.
- HOT_BASE, 12'hFF4, offset of hotspot 0 within the cartridge window; hotspot i is at HOT_BASE+i.
- RESET_BANK, NUM_BANKS-1, bank selected after reset.
- SC_RAM, 0, 1 enables the 128-byte Superchip RAM.
- BANK_W, derived, max(1, log2(NUM_BANKS)).

- CLOCKBUS  in  1  bus clock; one CPU bus cycle per edge.
- RES  in  1  synchronous, active-high reset.
- BUS_VALID  in  1  bus cycle is real. It is RDY-qualified and low during TIA WSYNC stalls.
- CPU_Addr  in  13  CPU address.
- CPU_R_W_n  in  1  1 = read, 0 = write.
- CPU_Dout  in  8  CPU write data.
- CPU_Din  out  8  read data mux to the CPU.
- TIA_Dout, RIOT_Dout, ROM_Dout  in  8 each  peripheral read data.
- TIA_SEL, RIOT_SEL, ROM_CS  out  1 each  region selects (combinational).
- ROM_Addr  out  12+BANK_W  {bank, CPU_Addr[11:0]}.
- BANK  out  BANK_W  current bank register.

## Operation
- Address decode (combinational):
  - A12=1 → cartridge window.
  - else A7=1 → RIOT.
  - else → TIA.
  - Exactly one of TIA_SEL / RIOT_SEL / ROM_CS is high.
- Superchip (SC_RAM=1):
  - Write port is $1000–$107F; read port is $1080–$10FF, both using RAM index A[6:0].
  - ROM_CS is low for both ports.
- Hotspot hit: BUS_VALID=1, A12=1, and A[11:0] within HOT_BASE..HOT_BASE+NUM_BANKS-1.
  - Reads and writes both trigger.
  - On a hit, BANK ← A[11:0]-HOT_BASE at the clock edge.
  - NUM_BANKS=1: no hotspots and BANK is constant 0.
- RAM write: write-port address, CPU_R_W_n=0 and BUS_VALID=1 → ram[A[6:0]] ← CPU_Dout at the edge.
- CPU_Din by priority:
  - Read port: ram[A[6:0]] (asynchronous read).
  - Read of the write port: 8'hFF, with no write.
  - ROM_CS: ROM_Dout.
  - RIOT_SEL: RIOT_Dout.
  - Otherwise: TIA_Dout.
- BUS_VALID=0:
  - No bank change and no RAM write.
  - Decode and mux still follow the address.

## Timing
- Reset values:
  - BANK = RESET_BANK.
  - All selects, ROM_Addr and CPU_Din are combinational from inputs and BANK.
  - RAM contents are not cleared by RES.
- Bank switch latency:
  - The hotspot cycle itself is served from the old bank.
  - The new bank is visible on ROM_Addr from the next cycle.
- Repeated hits to the same hotspot are idempotent.
- Back-to-back hits to different hotspots: the last one wins, one cycle each.
- RES asserted coincident with a hit: reset wins and BANK = RESET_BANK.
- RES mid-stall (BUS_VALID low): BANK = RESET_BANK on the next edge.
- A hotspot address overlapping the Superchip range is an illegal parameter set.
  - Flag it with an elaboration-time assertion.
- RAM read-after-write: a write at edge n is visible on the read port in cycle n+1.
- No write-to-read bypass is needed, because the ports are different addresses.
- Decode and mux are purely combinational with zero latency.
- CPU_Din must settle within one CLOCKBUS period, because the CPU samples at the end of the cycle.

## Structure
- Shared package atari_bus_pkg holds:
  - Region enum {REG_TIA, REG_RIOT, REG_ROM, REG_SCRAM_RD, REG_SCRAM_WR}.
  - Constants CART_A12_BIT, RIOT_A7_BIT.
  - Superchip base offsets 12'h000 / 12'h080.
  - The hotspot defaults for F8 (12'hFF8, 2 banks), F6 (12'hFF6, 4 banks) and F4 (12'hFF4, 8 banks).
- One sub-module, superchip_ram: 128×8, synchronous write, asynchronous read. It is generated only when SC_RAM=1.
- Decode, bank register and read mux live in atari_cart_mapper.

## Test plan
- Reset with NUM_BANKS=8 → BANK=7 and ROM_Addr[14:12]=3'b111. A read at $1000 returns ROM_Dout and CPU_Din follows it.
- Read $1FF6 (hotspot 2) with BUS_VALID=1:
  - That cycle, ROM_Addr = 15'h7FF6.
  - Next cycle, BANK=2 and a read at $1100 gives ROM_Addr = 15'h2100.
- Same hotspot access with BUS_VALID=0 → BANK unchanged. A write to $1FF4 with BUS_VALID=1 → BANK=0.
- SC_RAM=1:
  - Write $A5 to $1012 → a read of $1092 next cycle returns $A5 and ROM_CS stays low.
  - A read of $1012 returns $FF and leaves RAM unchanged.
- Decode sweep:
  - $0080 → RIOT_SEL, CPU_Din = RIOT_Dout.
  - $0002 → TIA_SEL, CPU_Din = TIA_Dout.
  - $1FFC → ROM_CS.
  - Exactly one select is high for every address.
- RES during back-to-back hits $1FF5 then $1FF9:
  - RES at the second edge → BANK=7.
  - Without RES → BANK=1, then 5.
